// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: 16x oversampled UART receive stage; recovers 8 data bits and
// checks optional parity and one or two stop bits.
module uart_rx_sipo #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  output logic [7:0] data_out,
  output logic       rx_active,
  output logic       rx_done,
  output logic       parity_error,
  output logic       framing_error
);
  localparam logic [3:0] MID = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t     state_q;
  logic [1:0] sync_q, par_q;
  logic       prev_q, stop2_q, perr_q, rx_s, fin;
  logic [3:0] tick_cnt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] sh_q;
  assign rx_s = sync_q[1];
  // frame ends on a failing first stop bit, a single stop bit, or the second stop bit
  assign fin = sample_tick && tick_cnt_q == LAST &&
               (state_q == STOP2 || (state_q == STOP1 && (!rx_s || !stop2_q)));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sync_q        <= 2'b11;
      prev_q        <= 1'b1;
      tick_cnt_q    <= '0;
      bit_idx_q     <= '0;
      sh_q          <= '0;
      par_q         <= '0;
      stop2_q       <= 1'b0;
      perr_q        <= 1'b0;
      data_out      <= '0;
      rx_active     <= 1'b0;
      rx_done       <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_in};
      rx_done <= 1'b0;
      if (sample_tick) begin
        prev_q     <= rx_s;
        tick_cnt_q <= tick_cnt_q + 4'd1;
        case (state_q)
          IDLE: begin
            tick_cnt_q <= '0;
            if (prev_q && !rx_s) begin
              state_q   <= START;
              rx_active <= 1'b1;
              par_q     <= parity_type;
              stop2_q   <= stop_bits;
              perr_q    <= 1'b0;
            end
          end
          START: if (tick_cnt_q == MID) begin
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            state_q    <= rx_s ? IDLE : DATA;
            rx_active  <= !rx_s;
          end
          DATA: if (tick_cnt_q == LAST) begin
            sh_q      <= {rx_s, sh_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= ^par_q ? PARITY : STOP1;
          end
          PARITY: if (tick_cnt_q == LAST) begin
            perr_q  <= ^{sh_q, rx_s, par_q[0]};
            state_q <= STOP1;
          end
          STOP1: if (tick_cnt_q == LAST && rx_s && stop2_q) state_q <= STOP2;
          STOP2: ;
          default: state_q <= IDLE;
        endcase
        if (fin) begin
          state_q       <= IDLE;
          data_out      <= sh_q;
          parity_error  <= perr_q;
          framing_error <= !rx_s;
          rx_done       <= 1'b1;
          rx_active     <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_sipo.sv
// tb_uart_rx_sipo: directed and random frames against a bit-list reference model.
module tb_uart_rx_sipo;
  logic       clk = 1'b0, rst = 1'b1, sample_tick = 1'b0, rx_in = 1'b1, stop_bits = 1'b0;
  logic [1:0] parity_type = 2'b00;
  logic [7:0] data_out;
  logic       rx_active, rx_done, parity_error, framing_error;
  int         checks = 0, failures = 0, tick_n = 0, done_cnt = 0, done_long = 0;
  int         act_ticks = 0, last_done = 0, exp_cnt = 0, t1;
  logic       was_done = 1'b0, cap_pe = 1'b0, cap_fe = 1'b0;
  logic [7:0] cap_d = '0, exp_d;
  logic       exp_pe, exp_fe;

  uart_rx_sipo dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_in(rx_in),
    .parity_type(parity_type), .stop_bits(stop_bits), .data_out(data_out),
    .rx_active(rx_active), .rx_done(rx_done), .parity_error(parity_error),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #2 sample_tick = ~sample_tick;
  end
  always @(posedge clk) if (sample_tick) tick_n++;
  always @(negedge clk) begin
    if (sample_tick && rx_active) act_ticks++;
    if (rx_done) begin
      if (was_done) done_long++;
      done_cnt++;
      cap_d     = data_out;
      cap_pe    = parity_error;
      cap_fe    = framing_error;
      last_done = tick_n;
    end
    was_done = rx_done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = tick_n + n;
    while (tick_n < k) @(negedge clk);
  endtask

  // Builds the line-level bit list from the frame rules, then drives it one bit per 16 ticks.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                            input logic bad_par, input logic s2);
    logic q[$];
    logic par_en = (pt == 2'b01) || (pt == 2'b10);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (par_en) q.push_back(((pt == 2'b01) ? ~^d : ^d) ^ bad_par);
    q.push_back(1'b1);
    if (sb) q.push_back(s2);
    exp_d  = d;
    exp_pe = par_en & bad_par;
    exp_fe = sb & ~s2;
    parity_type = pt;
    stop_bits   = sb;
    foreach (q[i]) begin
      rx_in = q[i];
      wait_ticks(16);
      if (i == 0) begin
        parity_type = 2'($urandom_range(0, 3));
        stop_bits   = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic check_frame(input string tag);
    exp_cnt++;
    chk({tag, "_done_cnt"}, done_cnt, exp_cnt);
    chk({tag, "_data"}, cap_d, exp_d);
    chk({tag, "_perr"}, cap_pe, exp_pe);
    chk({tag, "_ferr"}, cap_fe, exp_fe);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_active", rx_active, 1'b0);
    chk("rst_done", rx_done, 1'b0);
    chk("rst_perr", parity_error, 1'b0);
    chk("rst_ferr", framing_error, 1'b0);
    wait_ticks(10);
    act_ticks = 0;
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1);
    check_frame("a5");
    chk("a5_active_ticks", act_ticks, 152);
    send_frame(8'h3C, 2'b10, 1'b0, 1'b0, 1'b1);
    check_frame("3c_even_ok");
    send_frame(8'h3C, 2'b10, 1'b0, 1'b1, 1'b1);
    check_frame("3c_even_bad");
    send_frame(8'h3C, 2'b01, 1'b0, 1'b0, 1'b1);
    check_frame("3c_odd_ok");
    send_frame(8'hFF, 2'b00, 1'b1, 1'b0, 1'b0);
    check_frame("ff_stop2_bad");
    rx_in = 1'b1;
    wait_ticks(24);
    send_frame(8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
    check_frame("00");
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    wait_ticks(20);
    chk("glitch_active", rx_active, 1'b0);
    chk("glitch_no_done", done_cnt, exp_cnt);
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1);
    check_frame("55");
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    rx_in = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx_in = i == 0;
      wait_ticks(16);
    end
    rx_in = 1'b0;
    wait_ticks(8);
    chk("pre_rst_active", rx_active, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_active", rx_active, 1'b0);
    chk("mid_rst_done", rx_done, 1'b0);
    chk("mid_rst_perr", parity_error, 1'b0);
    chk("mid_rst_ferr", framing_error, 1'b0);
    rst   = 1'b0;
    rx_in = 1'b1;
    wait_ticks(20);
    chk("mid_rst_no_done", done_cnt, exp_cnt);
    send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1);
    check_frame("81");
    wait_ticks(5);
    send_frame(8'h12, 2'b01, 1'b0, 1'b0, 1'b1);
    check_frame("b2b_12");
    t1 = last_done;
    send_frame(8'h34, 2'b01, 1'b0, 1'b0, 1'b1);
    check_frame("b2b_34");
    chk("b2b_spacing", last_done - t1, 176);
    for (int n = 0; n < 10; n++) begin
      logic [7:0] d  = 8'($urandom);
      logic [1:0] pt = 2'($urandom_range(0, 3));
      logic       sb = 1'($urandom_range(0, 1));
      logic       bp = 1'($urandom_range(0, 1));
      send_frame(d, pt, sb, bp, 1'b1);
      check_frame("rand");
    end
    chk("done_width", done_long, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_sipo.md
# uart_rx_sipo

Serial-in/parallel-out receive stage for the UART link. It consumes the serial line driven by the transmit PISO and recovers the 8-bit payload. It uses a 16x oversampled start-bit search and mid-bit sampling, then checks parity and stop bits. It uses the same frame options as the transmit side (`parity_type`, `stop_bits`), so a TX→RX loopback must return the transmitted byte.

## Interface

Parameters:
- `OVERSAMPLE`, default 16. Number of `sample_tick` pulses per bit. Fixed at 16; other values are unsupported.

Ports:
- `clk`, input, 1 bit. Single clock; all state updates on its rising edge.
- `rst`, input, 1 bit. Synchronous, active-high reset.
- `sample_tick`, input, 1 bit. One-`clk` enable pulse at 16x the baud rate. The state machine advances only on cycles where it is high.
- `rx_in`, input, 1 bit. Asynchronous serial line; idles high.
- `parity_type`, input, 2 bits. 2'b00 or 2'b11: no parity bit. 2'b01: odd parity. 2'b10: even parity.
- `stop_bits`, input, 1 bit. 0: one stop bit. 1: two stop bits.
- `data_out`, output, 8 bits. Last received byte.
- `rx_active`, output, 1 bit. High while a frame is being received.
- `rx_done`, output, 1 bit. One-`clk` pulse at frame end.
- `parity_error`, output, 1 bit. Parity result of the last frame.
- `framing_error`, output, 1 bit. Stop-bit result of the last frame.

## Operation

- **Line format:** start bit (0), 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits (1). The longest frame is 12 bits, matching the transmit frame width.
- **Input synchronizer:** `rx_in` passes through a 2-flop synchronizer, producing `rx_s`. All decisions use `rx_s`.
- **Counters:**
  - `tick_cnt`, 4 bits, wraps 15→0.
  - `bit_idx`, 3 bits.
  - Both count only on `sample_tick`.
- **States:** IDLE, START, DATA, PARITY, STOP1, STOP2.
- **IDLE:**
  - On each tick, compare `rx_s` with its value at the previous tick.
  - A 1→0 transition moves to START, with `tick_cnt`=0 and `rx_active`=1.
  - A line that is already low when IDLE is entered does not start a frame. A high level must be seen first.
- **START:**
  - On the tick where `tick_cnt`==7 (mid start bit), sample `rx_s`.
  - If 0: go to DATA with `tick_cnt`=0 and `bit_idx`=0.
  - If 1: treat as a glitch. Return to IDLE, `rx_active`=0, no `rx_done`.
- **DATA:**
  - On each tick with `tick_cnt`==15, shift `rx_s` into the MSB of the shift register and shift the register right.
  - After bit 7, go to PARITY if parity is enabled, else to STOP1.
- **PARITY:**
  - At `tick_cnt`==15, sample the parity bit.
  - Error if the XOR of the 8 data bits and the parity bit is not 1 (odd parity) or not 0 (even parity).
  - Then go to STOP1.
- **STOP1:**
  - At `tick_cnt`==15, sample the stop bit.
  - If it is 0: framing error, frame ends.
  - Else if `stop_bits`=1: go to STOP2.
  - Else: frame ends.
- **STOP2:**
  - At `tick_cnt`==15, sample. A 0 is a framing error. The frame ends either way.
- **Frame end:**
  - Load `data_out` from the shift register.
  - Load `parity_error` (0 when parity is disabled) and `framing_error`.
  - Pulse `rx_done`, drop `rx_active`, go to IDLE.
  - A frame with errors still updates `data_out`.
- **Option latching:** `parity_type` and `stop_bits` are latched on the IDLE→START transition. Changes mid-frame have no effect on the current frame.
- **Error flags:** `parity_error` and `framing_error` hold their values until the next frame end.

## Timing

- **Reset values:**
  - `data_out`=8'h00, `rx_active`=0, `rx_done`=0, `parity_error`=0, `framing_error`=0.
  - State=IDLE, counters=0.
  - Synchronizer flops and previous-sample register reset to 1.
- **Reset mid-frame:** aborts immediately. There is no `rx_done` for the aborted frame, and outputs take their reset values on the next edge.
- **Start detection:** the line edge reaches `rx_s` after 2 `clk` cycles, then is seen at the next `sample_tick`.
- **Bit sampling:** each sample falls at 8 + 16·k ticks after start detection, for k = 1..(frame bits − 1).
- **`rx_done` timing:** high for exactly one `clk` cycle, in the cycle after the tick that samples the last stop bit or the failing stop bit.
- **Output update:** `data_out` and the error flags change in the same edge that raises `rx_done`.
- **Back-to-back frames:** a start edge on the tick following frame end is accepted. The IDLE previous-sample register holds the stop-bit value, so a 1→0 edge is detected.
- **Ticks vs `clk`:** `sample_tick` high for consecutive `clk` cycles counts as consecutive ticks. Nothing advances without ticks.

## Test plan

- 0xA5, no parity, 1 stop bit (line: 0,1,0,1,0,0,1,0,1,1) → one `rx_done` pulse, `data_out`=8'hA5, both errors 0, `rx_active` high for 160 ticks minus the start offset.
- 0x3C, even parity, parity bit 0 → `parity_error`=0. Repeat with parity bit 1 → `parity_error`=1 and `data_out`=8'h3C. Odd parity with parity bit 1 → `parity_error`=0.
- 0xFF, 2 stop bits, second stop bit driven 0 → `framing_error`=1 at the end of STOP2. Then a valid 0x00 frame → `framing_error`=0 and `data_out`=8'h00.
- Low pulse of 4 ticks on an idle line → no `rx_active` after the mid-start check, no `rx_done`. A following 0x55 frame decodes correctly.
- `rst` asserted at bit 4 of 0x81 → all outputs are reset values next cycle, no `rx_done`. Then 0x81 sent cleanly → `data_out`=8'h81.
- Two frames back-to-back, 0x12 then 0x34, odd parity, 1 stop bit, no idle gap → two `rx_done` pulses 176 ticks apart, values 8'h12 then 8'h34, no errors.
